// File: rtl/muldiv_iter.sv
// Iterative one-bit-per-cycle multiply/divide unit with valid/ready handshakes and flush.
// Defining MULDIV_ACCUMULATE_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, opnd_q;
    logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;

    logic               is_div;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_s, mul_res;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mag_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign mag_b = (op[0] && b[WIDTH-1]) ? -b : b;

    // Multiply: {hi_q, lo_q} shifts right, multiplier bits consumed from lo_q[0].
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: hi_q is the partial remainder, lo_q shifts the dividend out and quotient in.
    assign div_diff = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, opnd_q};

    assign prod_s  = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    // Divide-by-zero leaves |a| as remainder; sign fix-up restores the raw dividend.
    assign quo_fix = div_zero_q ? '1 : (neg_res_q ? -lo_q : lo_q);
    assign rem_fix = neg_rem_q ? -hi_q : hi_q;

`ifdef MULDIV_ACCUMULATE_EN
    logic               acc_en_q, acc_sub_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               unused_bits;

    assign is_div      = op[1] & ~op[2];
    assign mul_res     = !acc_en_q ? prod_s : (acc_sub_q ? acc_q - prod_s : acc_q + prod_s);
    assign unused_bits = div_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_en_q  <= 1'b0;
            acc_sub_q <= 1'b0;
            acc_q     <= '0;
        end else if (state_q == StIdle && in_valid && !flush) begin
            acc_en_q  <= op[2];
            acc_sub_q <= op[1];
            acc_q     <= {acc_hi, acc_lo};
        end
    end
`else
    logic unused_bits;

    assign is_div      = op[1];
    assign mul_res     = prod_s;
    assign unused_bits = ^{acc_hi, acc_lo, op[2], div_diff[WIDTH]};
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (flush && state_q != StIdle) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && !flush) begin
                        state_q    <= StBusy;
                        cnt_q      <= '0;
                        hi_q       <= '0;
                        lo_q       <= is_div ? mag_a : mag_b;
                        opnd_q     <= is_div ? mag_b : mag_a;
                        is_div_q   <= is_div;
                        neg_res_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_q  <= op[0] & a[WIDTH-1];
                        div_zero_q <= is_div && (b == '0);
                    end
                end
                StBusy: begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH+1]) begin
                            hi_q <= div_diff[WIDTH-1:0];
                            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_q <= {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_q <= mul_sum[WIDTH:1];
                        lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StFix: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= mul_res;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter at WIDTH=32.
module tb_muldiv_iter;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]   op;
    logic [W-1:0] a, b, acc_hi, acc_lo, hi, lo;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] rh, rl;
    int           lat, k, highs;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .acc_hi   (acc_hi),
        .acc_lo   (acc_lo),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts the accepting edge as cycle 1.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ah, input logic [W-1:0] al,
                          output logic [W-1:0] r_hi, output logic [W-1:0] r_lo, output int l);
        op = o; a = x; b = y; acc_hi = ah; acc_lo = al;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 200) begin
            tick();
            l++;
        end
        r_hi = hi;
        r_lo = lo;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; acc_hi = '0; acc_lo = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        run_op(3'b001, 32'hFFFF_FFFD, 32'h0000_0005, '0, '0, rh, rl, lat);
        check("mult_lat", lat, 34);
        check("mult_hi", rh, 32'hFFFF_FFFF);
        check("mult_lo", rl, 32'hFFFF_FFF1);
        check("retire_in_ready", in_ready, 1);

        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, rh, rl, lat);
        check("multu_hi", rh, 32'hFFFF_FFFE);
        check("multu_lo", rl, 32'h0000_0001);

        run_op(3'b001, 32'hFFFF_FFFD, 32'hFFFF_FFFB, '0, '0, rh, rl, lat);
        check("mult_nn_hi", rh, 32'h0000_0000);
        check("mult_nn_lo", rl, 32'h0000_000F);

        run_op(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, '0, '0, rh, rl, lat);
        check("div_lat", lat, 34);
        check("div_hi", rh, 32'hFFFF_FFFF);
        check("div_lo", rl, 32'hFFFF_FFFD);

        run_op(3'b011, 32'h0000_0007, 32'hFFFF_FFFE, '0, '0, rh, rl, lat);
        check("div_pn_hi", rh, 32'h0000_0001);
        check("div_pn_lo", rl, 32'hFFFF_FFFD);

        run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, rh, rl, lat);
        check("div_ovf_hi", rh, 32'h0000_0000);
        check("div_ovf_lo", rl, 32'h8000_0000);

        run_op(3'b010, 32'h0000_0064, 32'h0000_0007, '0, '0, rh, rl, lat);
        check("divu_hi", rh, 32'h0000_0002);
        check("divu_lo", rl, 32'h0000_000E);

        run_op(3'b010, 32'h0000_1234, 32'h0000_0000, '0, '0, rh, rl, lat);
        check("divu0_lat", lat, 34);
        check("divu0_hi", rh, 32'h0000_1234);
        check("divu0_lo", rl, 32'hFFFF_FFFF);

        run_op(3'b011, 32'hFFFF_FFF0, 32'h0000_0000, '0, '0, rh, rl, lat);
        check("div0_hi", rh, 32'hFFFF_FFF0);
        check("div0_lo", rl, 32'hFFFF_FFFF);

`ifdef MULDIV_ACCUMULATE_EN
        run_op(3'b101, 32'h0000_0002, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0010, rh, rl, lat);
        check("madd_lat", lat, 34);
        check("madd_hi", rh, 32'h0000_0000);
        check("madd_lo", rl, 32'h0000_000A);

        run_op(3'b110, 32'h0000_0002, 32'h0000_0003, '0, '0, rh, rl, lat);
        check("msubu_hi", rh, 32'hFFFF_FFFF);
        check("msubu_lo", rl, 32'hFFFF_FFFA);
`else
        run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, rh, rl, lat);
        check("op100_hi", rh, 32'hFFFF_FFFE);
        check("op100_lo", rl, 32'h0000_0001);

        run_op(3'b110, 32'h0000_0064, 32'h0000_0007, 32'h1111_1111, 32'h2222_2222, rh, rl, lat);
        check("op110_hi", rh, 32'h0000_0002);
        check("op110_lo", rl, 32'h0000_000E);

        run_op(3'b111, 32'hFFFF_FFF9, 32'h0000_0002, '0, '0, rh, rl, lat);
        check("op111_hi", rh, 32'hFFFF_FFFF);
        check("op111_lo", rl, 32'hFFFF_FFFD);
`endif

        // Backpressure: hold the result while a new request waits at the input.
        op = 3'b001; a = 32'hFFFF_FFFD; b = 32'h0000_0005;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        check("bp_wait", out_valid, 1);
        op = 3'b000; a = 32'h0000_0003; b = 32'h0000_0004;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_hi", hi, 32'hFFFF_FFFF);
            check("bp_lo", lo, 32'hFFFF_FFF1);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_retire_valid", out_valid, 0);
        check("bp_retire_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_next_accept", in_ready, 0);
        k = 0;
        while (!out_valid && k < 200) begin
            tick();
            k++;
        end
        check("bp_next_lo", lo, 32'h0000_000C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush during BUSY.
        op = 3'b000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("pre_flush_busy", in_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_out_valid", out_valid, 0);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) highs++;
        end
        check("flush_no_result", highs, 0);
        run_op(3'b000, 32'h0000_0003, 32'h0000_0004, '0, '0, rh, rl, lat);
        check("post_flush_lat", lat, 34);
        check("post_flush_hi", rh, 32'h0000_0000);
        check("post_flush_lo", rl, 32'h0000_000C);

        // Flush in IDLE blocks a simultaneous request.
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_block", in_ready, 1);

        // Reset in the middle of an operation.
        op = 3'b000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
